// File: rtl/cram_diag_loader_if.sv
// Request/response bundle between a diagnostic controller and the CRAM loader.
// Bit vectors keep the machine's MSB-first numbering ([0:N], bit 0 = MSB).
interface cram_diag_loader_if;
    logic        start;
    logic [0:10] adr;
    logic [0:79] data;
    logic        busy;
    logic        done;
    logic        diagLoadFunc;
    logic [4:6]  diag;
    logic        ebusDrive;
    logic [0:35] ebusData;

    modport master (
        output start, adr, data,
        input  busy, done, diagLoadFunc, diag, ebusDrive, ebusData
    );

    modport slave (
        input  start, adr, data,
        output busy, done, diagLoadFunc, diag, ebusDrive, ebusData
    );
endinterface

// File: rtl/cram_diag_loader.sv
// Loads one 80-bit CRAM word over EBUS using six diagnostic function phases
// (address low/high, then four 20-bit write slices), each setup/strobe/hold.
module cram_diag_loader #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2
) (
    input logic               clk,
    input logic               RESET_N,
    cram_diag_loader_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [2:0] SETUP_LAST  = 3'(SETUP_CYC - 1);
    localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYC - 1);
    localparam logic [2:0] LAST_PHASE  = 3'd5;

    state_t      state_q;
    logic [2:0]  phase_q;
    logic [2:0]  phase_d;
    logic [2:0]  cnt_q;
    logic [0:10] adr_q;
    logic [0:79] data_q;
    logic        busy_q;
    logic        done_q;
    logic        strobe_q;
    logic        drive_q;
    logic [4:6]  diag_q;
    logic [0:35] ebus_q;

    // The counter only spans one sub-step (setup or strobe), so 3 bits cover 1..7.
    assign phase_d = phase_q + 3'd1;

    function automatic logic [4:6] phaseDiag(input logic [2:0] p);
        case (p)
            3'd0:    phaseDiag = 3'd1;
            3'd1:    phaseDiag = 3'd2;
            3'd2:    phaseDiag = 3'd7;
            3'd3:    phaseDiag = 3'd6;
            3'd4:    phaseDiag = 3'd5;
            3'd5:    phaseDiag = 3'd4;
            default: phaseDiag = 3'd0;
        endcase
    endfunction

    function automatic logic [0:35] phaseEbus(input logic [2:0] p,
                                              input logic [0:10] a,
                                              input logic [0:79] d);
        logic [0:35] e;
        e = '0;
        case (p)
            3'd0:    e[0:5]  = a[5:10];
            3'd1:    e[1:5]  = a[0:4];
            3'd2:    e[0:19] = d[0:19];
            3'd3:    e[0:19] = d[20:39];
            3'd4:    e[0:19] = d[40:59];
            3'd5:    e[0:19] = d[60:79];
            default: e       = '0;
        endcase
        return e;
    endfunction

    // diag/ebusData are loaded only when a phase begins, keeping them stable across its strobe.
    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            cnt_q    <= '0;
            adr_q    <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            strobe_q <= 1'b0;
            drive_q  <= 1'b0;
            diag_q   <= '0;
            ebus_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        adr_q   <= bus.adr;
                        data_q  <= bus.data;
                        phase_q <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_SETUP;
                        busy_q  <= 1'b1;
                        drive_q <= 1'b1;
                        diag_q  <= phaseDiag(3'd0);
                        ebus_q  <= phaseEbus(3'd0, bus.adr, bus.data);
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= ST_STROBE;
                        strobe_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_STROBE: begin
                    if (cnt_q == STROBE_LAST) begin
                        cnt_q    <= '0;
                        state_q  <= ST_HOLD;
                        strobe_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_HOLD: begin
                    cnt_q <= '0;
                    if (phase_q == LAST_PHASE) begin
                        phase_q <= '0;
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        drive_q <= 1'b0;
                        done_q  <= 1'b1;
                        diag_q  <= '0;
                        ebus_q  <= '0;
                    end else begin
                        phase_q <= phase_d;
                        state_q <= ST_SETUP;
                        diag_q  <= phaseDiag(phase_d);
                        ebus_q  <= phaseEbus(phase_d, adr_q, data_q);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.diagLoadFunc = strobe_q;
    assign bus.ebusDrive    = drive_q;
    assign bus.diag         = diag_q;
    assign bus.ebusData     = ebus_q;
endmodule
